// File: rtl/alu_op_sequencer.sv
// Registered operand driver and result capture for the 4-bit AND/ADD/CMP units.
// One op in flight: accept, wait out the settle time, present the result until it is taken.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] unit_a,
    output logic [3:0] unit_b,
    input  logic [3:0] and_y,
    input  logic [3:0] add_y,
    input  logic       add_cout,
    input  logic       cmp_gt,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_y,
    output logic       out_carry,
    output logic       out_zero,
    output logic       out_err,
    output logic [7:0] op_count
);

    // state  | meaning
    // IDLE   | ready for a request; unit_a/unit_b keep the last operands
    // SETTLE | operands on the units, down-counting to the capture cycle
    // HOLD   | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       settle_done;
    logic [1:0] op_reg;
    logic [3:0] cap_y;
    logic       cap_carry;
    logic       cap_err;

    assign settle_done = (settle_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_done) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cap_y     = 4'd0;
        cap_carry = 1'b0;
        cap_err   = 1'b0;
        case (op_reg)
            OP_ADD: begin
                cap_y     = add_y;
                cap_carry = add_cout;
            end
            OP_AND:  cap_y = and_y;
            OP_CMP:  cap_y = {1'b0, cmp_gt, cmp_eq, cmp_lt};
            default: cap_err = 1'b1;
        endcase
    end

    // Unit results are only looked at on the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_a     <= 4'd0;
            unit_b     <= 4'd0;
            op_reg     <= 2'd0;
            settle_cnt <= 4'd0;
            out_y      <= 4'd0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            if (state == IDLE && in_valid) begin
                unit_a     <= in_a;
                unit_b     <= in_b;
                op_reg     <= in_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && !settle_done) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (state == SETTLE && settle_done) begin
                out_y     <= cap_y;
                out_carry <= cap_carry;
                out_zero  <= (cap_y == 4'd0);
                out_err   <= cap_err;
            end
            if (state == HOLD && out_ready) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 settles in 1 cycle, instance 1 in 3 cycles.
// Function units are modelled here; a noise input corrupts them outside the capture cycle.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [1:0] in_op     [2];
    logic [3:0] in_a      [2];
    logic [3:0] in_b      [2];
    logic [3:0] unit_a    [2];
    logic [3:0] unit_b    [2];
    logic [3:0] and_y     [2];
    logic [3:0] add_y     [2];
    logic       add_cout  [2];
    logic       cmp_gt    [2];
    logic       cmp_eq    [2];
    logic       cmp_lt    [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] out_y     [2];
    logic       out_carry [2];
    logic       out_zero  [2];
    logic       out_err   [2];
    logic [7:0] op_count  [2];
    logic       noise     [2];
    logic [7:0] exp_cnt   [2];

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .unit_a(unit_a[0]), .unit_b(unit_b[0]),
        .and_y(and_y[0]), .add_y(add_y[0]), .add_cout(add_cout[0]),
        .cmp_gt(cmp_gt[0]), .cmp_eq(cmp_eq[0]), .cmp_lt(cmp_lt[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]),
        .out_carry(out_carry[0]), .out_zero(out_zero[0]), .out_err(out_err[0]),
        .op_count(op_count[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3)) dut_s3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .unit_a(unit_a[1]), .unit_b(unit_b[1]),
        .and_y(and_y[1]), .add_y(add_y[1]), .add_cout(add_cout[1]),
        .cmp_gt(cmp_gt[1]), .cmp_eq(cmp_eq[1]), .cmp_lt(cmp_lt[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]),
        .out_carry(out_carry[1]), .out_zero(out_zero[1]), .out_err(out_err[1]),
        .op_count(op_count[1])
    );

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            and_y[g]               = (unit_a[g] & unit_b[g]) ^ {4{noise[g]}};
            {add_cout[g], add_y[g]} = ({1'b0, unit_a[g]} + {1'b0, unit_b[g]}) ^ {5{noise[g]}};
            cmp_gt[g]              = (unit_a[g] > unit_b[g]) ^ noise[g];
            cmp_eq[g]              = (unit_a[g] == unit_b[g]) ^ noise[g];
            cmp_lt[g]              = (unit_a[g] < unit_b[g]) ^ noise[g];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       carry;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Expected {err, zero, carry, y} straight from the opcode definitions.
    function automatic logic [6:0] ref_model(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        int sum;
        int y;
        int c;
        int e;
        c = 0;
        e = 0;
        y = 0;
        case (op)
            2'b00: begin
                sum = int'(a) + int'(b);
                y   = sum % 16;
                c   = (sum >= 16) ? 1 : 0;
            end
            2'b01: y = int'(a & b);
            2'b10: y = (a > b) ? 4 : ((a == b) ? 2 : 1);
            default: e = 1;
        endcase
        return {e[0], (y == 0), c[0], 4'(y)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int i, input string name);
        check({name, " unit_a"}, 32'(unit_a[i]), 0);
        check({name, " unit_b"}, 32'(unit_b[i]), 0);
        check({name, " out_y"}, 32'(out_y[i]), 0);
        check({name, " out_flags"}, {29'd0, out_carry[i], out_zero[i], out_err[i]}, 0);
        check({name, " out_valid"}, 32'(out_valid[i]), 0);
        check({name, " in_ready"}, 32'(in_ready[i]), 1);
        check({name, " op_count"}, 32'(op_count[i]), 0);
    endtask

    task automatic run_op(input int i, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [6:0] exp, input int hold,
                          input string name);
        int n;
        int lat;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            tick();
            n++;
        end
        check({name, " ready"}, 32'(in_ready[i]), 1);
        in_op[i]    = op;
        in_a[i]     = a;
        in_b[i]     = b;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        check({name, " unit_ab"}, {24'd0, unit_a[i], unit_b[i]}, {24'd0, a, b});
        check({name, " busy"}, {30'd0, in_ready[i], out_valid[i]}, 0);
        lat = 0;
        while (!out_valid[i] && lat < 40) begin
            noise[i] = (lat < s_of(i) - 1);
            tick();
            lat++;
        end
        noise[i] = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(s_of(i)));
        check({name, " result"}, {25'd0, out_err[i], out_zero[i], out_carry[i], out_y[i]},
              {25'd0, exp});
        in_a[i]     = ~a;
        in_b[i]     = ~b;
        in_valid[i] = (hold > 0);
        noise[i]    = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            check({name, " hold"}, {22'd0, out_valid[i], in_ready[i], out_y[i], unit_a[i]},
                  {22'd0, 1'b1, 1'b0, exp[3:0], a});
            check({name, " hold_cnt"}, 32'(op_count[i]), 32'(exp_cnt[i]));
        end
        in_valid[i]  = 1'b0;
        noise[i]     = 1'b0;
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
        exp_cnt[i]   = exp_cnt[i] + 8'd1;
        check({name, " released"}, {30'd0, out_valid[i], in_ready[i]}, {30'd0, 2'b01});
        check({name, " op_count"}, 32'(op_count[i]), 32'(exp_cnt[i]));
        check({name, " kept"}, {25'd0, out_err[i], out_zero[i], out_carry[i], out_y[i]},
              {25'd0, exp});
        check({name, " unit_keep"}, {24'd0, unit_a[i], unit_b[i]}, {24'd0, a, b});
    endtask

    initial begin
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         n;

        vecs[0] = '{2'b01, 4'b1010, 4'b1001, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 4'b0101, 4'b0101, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 4'b1100, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{2'b10, 4'b0001, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_op[i]     = 2'd0;
            in_a[i]      = 4'd0;
            in_b[i]      = 4'd0;
            out_ready[i] = 1'b0;
            noise[i]     = 1'b0;
            exp_cnt[i]   = 8'd0;
        end

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state(0, "rst0_s1");
        check_reset_state(1, "rst0_s3");

        for (int v = 0; v < 8; v++) begin
            run_op(0, vecs[v].op, vecs[v].a, vecs[v].b,
                   {vecs[v].err, vecs[v].zero, vecs[v].carry, vecs[v].y}, v % 3,
                   $sformatf("vec%0d", v));
        end

        // Backpressure with a request pending, then accepted right after release.
        in_op[0] = 2'b00; in_a[0] = 4'b0101; in_b[0] = 4'b0110; in_valid[0] = 1'b1;
        tick();
        in_op[0] = 2'b10; in_a[0] = 4'b0010; in_b[0] = 4'b0111;
        tick();
        check("bp captured", {27'd0, out_valid[0], out_y[0]}, {27'd0, 1'b1, 4'b1011});
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp stable", {22'd0, out_valid[0], in_ready[0], out_y[0], unit_a[0]},
                  {22'd0, 1'b1, 1'b0, 4'b1011, 4'b0101});
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        exp_cnt[0]   = exp_cnt[0] + 8'd1;
        check("bp count", 32'(op_count[0]), 32'(exp_cnt[0]));
        check("bp idle", {30'd0, out_valid[0], in_ready[0]}, {30'd0, 2'b01});
        tick();
        in_valid[0] = 1'b0;
        check("bp accept", {23'd0, in_ready[0], unit_a[0], unit_b[0]},
              {23'd0, 1'b0, 4'b0010, 4'b0111});
        tick();
        check("bp result", {27'd0, out_valid[0], out_y[0]}, {27'd0, 1'b1, 4'b0001});
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        exp_cnt[0]   = exp_cnt[0] + 8'd1;
        check("bp count2", 32'(op_count[0]), 32'(exp_cnt[0]));

        for (int r = 0; r < 40; r++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            run_op(0, op, a, b, ref_model(op, a, b), int'($urandom_range(0, 3)),
                   $sformatf("rnd_s1_%0d", r));
        end

        // Reset in the middle of SETTLE abandons the operation.
        in_op[1] = 2'b00; in_a[1] = 4'b1001; in_b[1] = 4'b0100; in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt[0] = 8'd0;
        exp_cnt[1] = 8'd0;
        check_reset_state(0, "rstmid_s1");
        check_reset_state(1, "rstmid_s3");
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid[0] || out_valid[1]) n++;
        end
        check("rstmid no_result", 32'(n), 0);

        for (int r = 0; r < 256; r++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            run_op(1, op, a, b, ref_model(op, a, b), int'($urandom_range(0, 2)),
                   $sformatf("rnd_s3_%0d", r));
        end
        check("wrap op_count", 32'(op_count[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
